// File: rtl/mdu_if.sv
// Request/result bundle between an issuing pipeline and the multiply/divide unit.
// The issuer holds the master view and the MDU holds the slave view.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mdu.sv
// Iterative signed/unsigned multiply-divide unit; MDU_FAST_MULT_EN swaps the shift-add multiply for one registered multiply.
// Latency WIDTH+2 cycles start-to-done (2 for fast multiply); start is ignored while busy, cancel flushes without done.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int                   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_bzero;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bmag;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic             r_done;
    logic             r_div_zero;

    logic             w_busy;
    logic             w_accept;
    logic             w_fix_fire;
    logic             w_fast_in;
    logic             w_signed_in;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_diff;
    logic               w_rem_ge;
    logic [2*WIDTH-1:0] w_prod_raw;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    // Operands are reduced to magnitudes at issue; signs are reapplied in FIX.
    assign w_signed_in = ~bus.op[0];
    assign w_a_neg     = w_signed_in & bus.a[WIDTH-1];
    assign w_b_neg     = w_signed_in & bus.b[WIDTH-1];
    assign w_amag      = w_a_neg ? (~bus.a + ONE_W) : bus.a;
    assign w_bmag      = w_b_neg ? (~bus.b + ONE_W) : bus.b;

`ifdef MDU_FAST_MULT_EN
    assign w_fast_in = ~bus.op[1];
`else
    assign w_fast_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_fix_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_fast_in ? FIX : CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (bus.cancel) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = IDLE;
                w_fix_fire  = ~bus.cancel;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend->quotient}.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bmag} : '0);
    assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_bmag});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_bmag;

`ifdef MDU_FAST_MULT_EN
    assign w_prod_raw = {{WIDTH{1'b0}}, r_lo} * {{WIDTH{1'b0}}, r_bmag};
`else
    assign w_prod_raw = {r_hi, r_lo};
`endif

    assign w_prod_fix = r_neg_lo ? (~w_prod_raw + ONE_2W) : w_prod_raw;
    assign w_quo_fix  = r_neg_lo ? (~r_lo + ONE_W) : r_lo;
    assign w_rem_fix  = r_neg_hi ? (~r_hi + ONE_W) : r_hi;

    // Most-negative / -1 needs no special case: the quotient magnitude 2^(WIDTH-1) stays positive.
    always_comb begin
        w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_bzero) begin
                w_fin_hi = r_a;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = w_rem_fix;
                w_fin_lo = w_quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_bzero    <= 1'b0;
            r_a        <= '0;
            r_bmag     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_res_hi   <= '0;
            r_res_lo   <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= w_fix_fire;
            r_div_zero <= w_fix_fire & r_is_div & r_bzero;
            if (w_fix_fire) begin
                r_res_hi <= w_fin_hi;
                r_res_lo <= w_fin_lo;
            end
            if (w_accept) begin
                r_cnt    <= '0;
                r_is_div <= bus.op[1];
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_bzero  <= (bus.b == '0);
                r_a      <= bus.a;
                r_bmag   <= w_bmag;
                r_hi     <= '0;
                r_lo     <= w_amag;
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + CNT_ONE;
                if (r_is_div) begin
                    r_hi <= w_rem_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], w_rem_ge};
                end else begin
                    r_hi <= w_mul_sum[WIDTH:1];
                    r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                end
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.hi       = r_res_hi;
    assign bus.lo       = r_res_lo;
    assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu at WIDTH=32: arithmetic vectors, latency, cancel, back-to-back issue and reset.
// Fast-multiply expectations follow MDU_FAST_MULT_EN when the bench is built with it.
module tb_mdu;
    localparam int         W     = 32;
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst;

    mdu_if #(.WIDTH(W)) bus ();

    mdu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_hi_q = '0;
    logic [W-1:0] exp_lo_q = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_for(input logic [1:0] op);
        int l;
        l = W + 2;
`ifdef MDU_FAST_MULT_EN
        if (!op[1]) l = 2;
`endif
        return l;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Called with start already driven; returns at the negedge of the done cycle.
    task automatic collect(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz, input int elat, input bit pulse);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, ".busy"}, 64'(bus.busy), 64'd1);
            if (bus.done) lat = k;
            else if (pulse && k == 5) issue(2'($urandom), $urandom, $urandom);
            else if (pulse && k == 6) bus.start = 1'b0;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".hi"}, 64'(bus.hi), 64'(eh));
        check({tag, ".lo"}, 64'(bus.lo), 64'(el));
        check({tag, ".dz"}, 64'(bus.div_zero), 64'(edz));
        exp_hi_q = eh;
        exp_lo_q = el;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz);
        @(negedge clk);
        issue(op, a, b);
        collect(tag, eh, el, edz, lat_for(op), 1'b0);
        @(negedge clk);
        check({tag, ".pulse"}, 64'({bus.done, bus.div_zero}), 64'd0);
        check({tag, ".hold"}, {bus.hi, bus.lo}, {eh, el});
    endtask

    // Starts DIVU 100/7 and raises cancel in cycle T+cyc; returns at the negedge of T+cyc+1.
    task automatic cancel_test(input string tag, input int cyc);
        int dones;
        dones = 0;
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= cyc; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (k == cyc) bus.cancel = 1'b1;
        end
        @(negedge clk);
        bus.cancel = 1'b0;
        if (bus.done) dones++;
        check({tag, ".nodone"}, 64'(dones), 64'd0);
        check({tag, ".busy"}, 64'(bus.busy), 64'd0);
        check({tag, ".hold"}, {bus.hi, bus.lo}, {exp_hi_q, exp_lo_q});
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int dones;
        dones = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check({tag, ".extra_done"}, 64'(dones), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.cancel = 1'b0;
        bus.op     = MULTU;
        bus.a      = 32'd5;
        bus.b      = 32'd6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.dz", 64'(bus.div_zero), 64'd0);
        check("rst.hilo", {bus.hi, bus.lo}, 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;

        run_op("mult_neg",  MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu",     MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0);
        run_op("mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_mix",  MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("div_neg",   DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_negb",  DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("div_nn",    DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0);
        run_op("divu",      DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
        run_op("divu_big",  DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0);
        run_op("divu_msb",  DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        run_op("divu_z",    DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        run_op("div_z",     DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

        // Cancel mid-CALC, then restart in the very next cycle.
        cancel_test("cancel_calc", 10);
        issue(DIVU, 32'd100, 32'd7);
        collect("after_cancel", 32'd2, 32'd14, 1'b0, lat_for(DIVU), 1'b0);
        @(negedge clk);

        // Cancel in the FIX cycle suppresses the done that would follow.
        cancel_test("cancel_fix", W + 1);

        // Cancel beats a simultaneous start in IDLE.
        @(negedge clk);
        issue(DIVU, 32'd9, 32'd3);
        bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_start.busy", 64'(bus.busy), 64'd0);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        count_dones("cancel_start", W + 4);

        // Back-to-back: second start presented in the done cycle, stray starts while busy.
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7);
        collect("b2b1", 32'd2, 32'd14, 1'b0, lat_for(DIVU), 1'b0);
        issue(MULTU, 32'd6, 32'd7);
        collect("b2b2", 32'd0, 32'd42, 1'b0, lat_for(MULTU), 1'b1);
        count_dones("b2b2", W + 4);

        // Reset mid-divide with start held: everything clears, nothing is accepted.
        @(negedge clk);
        issue(DIVU, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        issue(DIV, 32'd5, 32'd1);
        @(negedge clk);
        check("rst_mid.busy", 64'(bus.busy), 64'd0);
        check("rst_mid.done", 64'(bus.done), 64'd0);
        check("rst_mid.dz", 64'(bus.div_zero), 64'd0);
        check("rst_mid.hilo", {bus.hi, bus.lo}, 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_mid.idle", 64'(bus.busy), 64'd0);
        count_dones("rst_mid", W + 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
